// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-requester holding buffers feeding a single CDB writeback
// port through a round-robin arbiter. The buffers allow a granted requester
// to refill in the same cycle, so the port sustains one beat per cycle.
module cdb_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int PREG_W = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*PREG_W-1:0] req_preg,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic                   flush,
    output logic                   wb_valid,
    output logic [PREG_W-1:0]      wb_preg,
    output logic [DATA_W-1:0]      wb_data,
    output logic [1:0]             wb_src,
    output logic [15:0]            conflict_cnt
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   r_buf_valid;
    logic [PREG_W-1:0] r_buf_preg [NREQ];
    logic [DATA_W-1:0] r_buf_data [NREQ];
    logic [IDX_W-1:0]  r_rr_ptr;
    logic              r_wb_valid;
    logic [PREG_W-1:0] r_wb_preg;
    logic [DATA_W-1:0] r_wb_data;
    logic [1:0]        r_wb_src;
    logic [15:0]       r_conflict_cnt;

    logic [NREQ-1:0]   w_grant;
    logic [NREQ-1:0]   w_load;
    logic [IDX_W-1:0]  w_grant_idx;
    logic [IDX_W-1:0]  w_rr_next;
    logic              w_any;
    logic              w_fire;
    logic              w_multi;

    // Round-robin search over occupied buffers, starting at the pointer
    always_comb begin : grant_search
        int unsigned cand;
        w_grant     = '0;
        w_grant_idx = '0;
        w_any       = 1'b0;
        cand        = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(r_rr_ptr) + k) % NREQ;
            if (!w_any && r_buf_valid[IDX_W'(cand)]) begin
                w_any                      = 1'b1;
                w_grant_idx                = IDX_W'(cand);
                w_grant[IDX_W'(cand)]      = 1'b1;
            end
        end
    end

    // A flush cycle produces no beat and leaves the pointer alone
    assign w_fire    = w_any & ~flush;
    // x & (x-1) is non-zero exactly when two or more buffers are occupied
    assign w_multi   = |(r_buf_valid & (r_buf_valid - NREQ'(1)));
    assign w_rr_next = (w_grant_idx == IDX_W'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;

    assign req_ready = flush ? '1 : (~r_buf_valid | w_grant);
    assign w_load    = req_valid & req_ready & {NREQ{~flush}};

    // Buffer occupancy: load wins over the grant's release (pass-through refill)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buf_valid <= '0;
        end else if (flush) begin
            r_buf_valid <= '0;
        end else begin
            r_buf_valid <= w_load | (r_buf_valid & ~w_grant);
        end
    end

    // Buffer payload capture; only meaningful while the matching valid is set
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_load[i]) begin
                r_buf_preg[i] <= req_preg[i*PREG_W +: PREG_W];
                r_buf_data[i] <= req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Registered writeback beat and round-robin pointer update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_valid <= 1'b0;
            r_wb_preg  <= '0;
            r_wb_data  <= '0;
            r_wb_src   <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_wb_valid <= w_fire;
            if (w_fire) begin
                r_wb_preg <= r_buf_preg[w_grant_idx];
                r_wb_data <= r_buf_data[w_grant_idx];
                r_wb_src  <= 2'(w_grant_idx);
                r_rr_ptr  <= w_rr_next;
            end
        end
    end

    // Saturating count of cycles with more than one occupied buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_conflict_cnt <= '0;
        end else if (!flush && w_multi && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign wb_valid     = r_wb_valid;
    assign wb_preg      = r_wb_preg;
    assign wb_data      = r_wb_data;
    assign wb_src       = r_wb_src;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus for cdb_arbiter with a per-cycle
// behavioural model comparison plus hand-computed literal expectations.
module tb_cdb_arbiter;

    localparam int NREQ   = 3;
    localparam int DATA_W = 32;
    localparam int PREG_W = 7;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*PREG_W-1:0] req_preg = '0;
    logic [NREQ*DATA_W-1:0] req_data = '0;
    logic                   flush = 1'b0;
    logic                   wb_valid;
    logic [PREG_W-1:0]      wb_preg;
    logic [DATA_W-1:0]      wb_data;
    logic [1:0]             wb_src;
    logic [15:0]            conflict_cnt;

    cdb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .PREG_W(PREG_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_preg(req_preg), .req_data(req_data),
        .flush(flush),
        .wb_valid(wb_valid), .wb_preg(wb_preg), .wb_data(wb_data),
        .wb_src(wb_src), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- source queues (one per requester) ----------------
    typedef struct { logic [PREG_W-1:0] p; logic [DATA_W-1:0] d; } item_t;
    item_t srcq [NREQ][$];
    bit    hs   [NREQ];
    bit    preload = 1'b0;

    // ---------------- behavioural model ----------------
    typedef struct { bit v; logic [PREG_W-1:0] p; logic [DATA_W-1:0] d; } ent_t;
    ent_t              mb [NREQ];
    int                m_rr  = 0;
    bit                m_wbv = 1'b0;
    logic [PREG_W-1:0] m_wp  = '0;
    logic [DATA_W-1:0] m_wd  = '0;
    int                m_ws  = 0;
    int                m_cnt = 0;

    always @(negedge clk) begin : cmp
        int g;
        int nv;
        logic [NREQ-1:0] er;
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) mb[i].v = 1'b0;
            m_rr = 0; m_wbv = 1'b0; m_cnt = 0;
            chk("rst_req_ready", req_ready, {NREQ{1'b1}});
            chk("rst_wb_valid", wb_valid, 0);
            chk("rst_conflict_cnt", conflict_cnt, 0);
        end else begin
            if (preload) m_cnt = 32'hFFFE;
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && mb[(m_rr + k) % NREQ].v) g = (m_rr + k) % NREQ;
            nv = 0;
            for (int i = 0; i < NREQ; i++) if (mb[i].v) nv++;
            for (int i = 0; i < NREQ; i++) er[i] = flush || !mb[i].v || (g == i);
            chk("model_req_ready", req_ready, er);
            chk("model_wb_valid", wb_valid, m_wbv);
            if (m_wbv) begin
                chk("model_wb_preg", wb_preg, m_wp);
                chk("model_wb_data", wb_data, m_wd);
                chk("model_wb_src", wb_src, m_ws);
            end
            chk("model_conflict_cnt", conflict_cnt, m_cnt);
            if (flush) begin
                for (int i = 0; i < NREQ; i++) mb[i].v = 1'b0;
                m_wbv = 1'b0;
            end else begin
                m_wbv = (g >= 0);
                if (g >= 0) begin
                    m_wp = mb[g].p; m_wd = mb[g].d; m_ws = g;
                    m_rr = (g + 1) % NREQ;
                    mb[g].v = 1'b0;
                end
                if (nv >= 2 && m_cnt < 65535) m_cnt++;
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i] && er[i]) begin
                        mb[i].v = 1'b1;
                        mb[i].p = req_preg[i*PREG_W +: PREG_W];
                        mb[i].d = req_data[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
        for (int i = 0; i < NREQ; i++) hs[i] = req_valid[i] && req_ready[i];
    end

    // Advance one cycle: retire accepted items, present queue heads.
    // Returns 2 ns after the rising edge.
    task automatic step();
        item_t tmp;
        @(posedge clk);
        preload = 1'b0;
        #1;
        for (int i = 0; i < NREQ; i++)
            if (hs[i] && srcq[i].size() > 0) tmp = srcq[i].pop_front();
        for (int i = 0; i < NREQ; i++) begin
            if (srcq[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_preg[i*PREG_W +: PREG_W] = srcq[i][0].p;
                req_data[i*DATA_W +: DATA_W] = srcq[i][0].d;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic push(input int r, input logic [PREG_W-1:0] p, input logic [DATA_W-1:0] d);
        item_t it;
        it.p = p; it.d = d;
        srcq[r].push_back(it);
    endtask

    task automatic rst_pulse();
        #1 reset = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
    endtask

    int beats;

    initial begin
        // ---- reset state ----
        step(); step();
        chk("reset_ready", req_ready, 3'b111);
        chk("reset_wb_valid", wb_valid, 0);
        chk("reset_cnt", conflict_cnt, 0);
        reset = 1'b1;
        step(); step();

        // ---- single beat from requester 1 ----
        push(1, 7'h05, 32'hDEADBEEF);
        step();                       // handshake cycle t
        step();                       // t+1
        step();                       // t+2
        chk("single_wb_valid", wb_valid, 1);
        chk("single_wb_preg", wb_preg, 7'h05);
        chk("single_wb_data", wb_data, 32'hDEADBEEF);
        chk("single_wb_src", wb_src, 1);
        step();                       // t+3
        chk("single_wb_valid_off", wb_valid, 0);

        // ---- three-way contention from rr_ptr=0 ----
        rst_pulse();
        push(0, 7'h10, 32'h100); push(1, 7'h11, 32'h111); push(2, 7'h12, 32'h122);
        step();                       // t
        step();                       // t+1
        chk("contend_ready_t1", req_ready, 3'b001);
        step();                       // t+2
        chk("contend_ready_t2", req_ready, 3'b011);
        chk("contend_src0", wb_src, 0);
        chk("contend_preg0", wb_preg, 7'h10);
        step();                       // t+3
        chk("contend_ready_t3", req_ready, 3'b111);
        chk("contend_src1", wb_src, 1);
        step();                       // t+4
        chk("contend_src2", wb_src, 2);
        chk("contend_valid2", wb_valid, 1);
        chk("contend_cnt", conflict_cnt, 2);
        step();
        chk("contend_done", wb_valid, 0);

        // ---- fairness: requesters 0 and 2 streaming ----
        for (int k = 0; k < 5; k++) begin
            push(0, 7'(8'h30 + k), 32'h3000 + k);
            push(2, 7'(8'h40 + k), 32'h4000 + k);
        end
        beats = 0;
        step();                       // t
        for (int k = 1; k <= 14; k++) begin
            step();                   // t+k
            if (k >= 2 && k <= 11) begin
                chk("fair_valid", wb_valid, 1);
                chk("fair_src", wb_src, ((k - 2) % 2 == 0) ? 0 : 2);
            end else begin
                chk("fair_idle", wb_valid, 0);
            end
            if (wb_valid) beats++;
        end
        chk("fair_beats", beats, 10);

        // ---- flush with buffers 0 and 2 occupied ----
        push(0, 7'h20, 32'h2020); push(2, 7'h22, 32'h2222);
        step();                       // t
        step();                       // t+1: both buffers valid
        flush = 1'b1;
        #1 chk("flush_ready", req_ready, 3'b111);
        step();                       // t+2
        flush = 1'b0;
        chk("flush_wb_off", wb_valid, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("flush_no_stale", wb_valid, 0);
        end
        push(1, 7'h25, 32'hCAFE0025);
        step(); step(); step();
        chk("postflush_valid", wb_valid, 1);
        chk("postflush_preg", wb_preg, 7'h25);
        chk("postflush_src", wb_src, 1);

        // ---- asynchronous reset with buffers full ----
        push(0, 7'h50, 32'h5050); push(1, 7'h51, 32'h5151); push(2, 7'h52, 32'h5252);
        step();                       // t
        step();                       // t+1: all buffers full
        #1 reset = 1'b0;
        #1;
        chk("arst_wb_valid", wb_valid, 0);
        chk("arst_wb_preg", wb_preg, 0);
        chk("arst_wb_data", wb_data, 0);
        chk("arst_wb_src", wb_src, 0);
        chk("arst_cnt", conflict_cnt, 0);
        chk("arst_ready", req_ready, 3'b111);
        step(); step();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("arst_no_stale", wb_valid, 0);
        end

        // ---- counter saturation ----
        for (int k = 0; k < 3; k++) begin
            push(0, 7'(8'h60 + k), 32'h6000 + k);
            push(1, 7'(8'h70 + k), 32'h7000 + k);
        end
        step();                       // t
        step();                       // t+1: contention begins
        force dut.r_conflict_cnt = 16'hFFFE;
        preload = 1'b1;
        #1 release dut.r_conflict_cnt;
        step();                       // t+2
        chk("sat_first", conflict_cnt, 16'hFFFF);
        for (int k = 0; k < 5; k++) step();
        chk("sat_hold", conflict_cnt, 16'hFFFF);
        step(); step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #200000;
        n_err++;
        $display("FAIL timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "timeout");
    end

endmodule
